fpu_sp_adder: RTL and testbench

- IEEE-754 binary32 adder/subtractor core. It computes a + b, where subtraction is done by negating the sign of b upstream.
- The result is registered with 1-cycle latency. It sits in the FPU datapath beside the multiplier and divider.
- Provides overflow and underflow flags.

---
 rtl/fpu_sp_pkg.sv | 18 +
 rtl/fpu_sp_adder_if.sv | 22 ++
 rtl/fpu_sp_lzc.sv | 15 +
 rtl/fpu_sp_adder.sv | 146 ++++++++++++++
 tb/tb_fpu_sp_adder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/fpu_sp_pkg.sv
// Shared binary32 constants and field layout for the single-precision FPU blocks.
package fpu_sp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpu_sp_adder_if.sv
// Operand/result bundle between an FPU issue stage and the binary32 adder.
interface fpu_sp_adder_if;

  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        out_valid;
  logic        overflow;
  logic        underflow;

  modport master (
    output in_valid, a, b,
    input  result, out_valid, overflow, underflow
  );

  modport slave (
    input  in_valid, a, b,
    output result, out_valid, overflow, underflow
  );

endinterface

// File: rtl/fpu_sp_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input reports 28.
module fpu_sp_lzc (
  input  logic [27:0] value,
  output logic [4:0]  zeros_c
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    zeros_c = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) zeros_c = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fpu_sp_adder.sv
// IEEE-754 binary32 adder: flush-to-zero, round-to-nearest-even, one register stage.
module fpu_sp_adder
  import fpu_sp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  fpu_sp_adder_if.slave bus
);

  localparam int unsigned MANT_W = FRAC_W + 1;
  localparam int unsigned EXT_W  = MANT_W + 3;
  localparam int unsigned SUM_W  = EXT_W + 1;
  localparam int unsigned WIDE_W = 2 * MANT_W + 2;

  generate
    if (WIDTH != 32) begin : g_width_check
      $error("fpu_sp_adder supports WIDTH=32 only");
    end
  endgenerate

  fp32_t ua, ub;
  assign ua = fp32_t'(bus.a);
  assign ub = fp32_t'(bus.b);

  logic a_nan, b_nan, a_inf, b_inf;
  assign a_nan = (ua.exp == 8'hFF) && (ua.frac != '0);
  assign b_nan = (ub.exp == 8'hFF) && (ub.frac != '0);
  assign a_inf = (ua.exp == 8'hFF) && (ua.frac == '0);
  assign b_inf = (ub.exp == 8'hFF) && (ub.frac == '0);

  // Denormals carry exp=0, so a zero mantissa flushes them on input.
  logic [MANT_W-1:0] mant_a, mant_b;
  assign mant_a = (ua.exp != '0) ? {1'b1, ua.frac} : '0;
  assign mant_b = (ub.exp != '0) ? {1'b1, ub.frac} : '0;

  logic              sign_x, sign_y;
  logic [EXP_W-1:0]  exp_x, diff;
  logic [MANT_W-1:0] mant_x, mant_y;
  logic [WIDE_W-1:0] y_wide;
  logic [EXT_W-1:0]  x_ext, y_ext;
  logic [SUM_W-1:0]  sum;
  logic [4:0]        lz;

  always_comb begin
    if ({ua.exp, mant_a} >= {ub.exp, mant_b}) begin
      sign_x = ua.sign; exp_x = ua.exp; mant_x = mant_a;
      sign_y = ub.sign; diff  = ua.exp - ub.exp; mant_y = mant_b;
    end else begin
      sign_x = ub.sign; exp_x = ub.exp; mant_x = mant_b;
      sign_y = ua.sign; diff  = ub.exp - ua.exp; mant_y = mant_a;
    end
  end

  // Low 24 bits of the wide shift are everything pushed past the round bit.
  assign y_wide = {mant_y, 26'd0} >> diff;
  assign x_ext  = {mant_x, 3'b000};
  assign y_ext  = (diff >= 8'd27) ? {26'd0, |mant_y}
                                  : {y_wide[WIDE_W-1:24], |y_wide[23:0]};
  assign sum    = (sign_x ^ sign_y) ? ({1'b0, x_ext} - {1'b0, y_ext})
                                    : ({1'b0, x_ext} + {1'b0, y_ext});

  fpu_sp_lzc u_lzc (
    .value   (sum),
    .zeros_c (lz)
  );

  logic [EXT_W-1:0] norm;
  logic [SUM_W-1:0] shifted;
  logic [9:0]       exp_n, exp_r;
  logic             round_up;
  logic [MANT_W:0]  mant_r;
  logic [FRAC_W-1:0] frac_f;

  // Normalize to a leading one at bit 26, then round on guard/round/sticky.
  always_comb begin
    shifted = sum << (lz - 5'd1);
    if (sum[SUM_W-1]) begin
      norm  = {sum[SUM_W-1:2], sum[1] | sum[0]};
      exp_n = 10'(exp_x) + 10'd1;
    end else begin
      norm  = shifted[EXT_W-1:0];
      exp_n = 10'(exp_x) + 10'd1 - 10'(lz);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[EXT_W-1:3]} + (MANT_W+1)'(round_up);
    if (mant_r[MANT_W]) begin
      frac_f = mant_r[MANT_W-1:1];
      exp_r  = exp_n + 10'd1;
    end else begin
      frac_f = mant_r[FRAC_W-1:0];
      exp_r  = exp_n;
    end
  end

  logic [31:0] res_c;
  logic        ovf_c, unf_c;

  always_comb begin
    res_c = {sign_x, exp_r[EXP_W-1:0], frac_f};
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign))) begin
      res_c = QNAN;
    end else if (a_inf) begin
      res_c = bus.a;
    end else if (b_inf) begin
      res_c = bus.b;
    end else if (sum == '0) begin
      // Only -0 + -0 keeps a negative sign; true cancellation gives +0.
      res_c = {(mant_a == '0) && (mant_b == '0) && ua.sign && ub.sign, 31'd0};
    end else if (!exp_r[9] && (exp_r >= 10'(EXP_MAX))) begin
      res_c = POS_INF | {sign_x, 31'd0};
      ovf_c = 1'b1;
    end else if (exp_r[9] || (exp_r == 10'd0)) begin
      res_c = {sign_x, 31'd0};
      unf_c = 1'b1;
    end
  end

  logic [31:0] result_q;
  logic        valid_q, ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= res_c;
        ovf_q    <= ovf_c;
        unf_q    <= unf_c;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_fpu_sp_adder.sv
// Self-checking bench for fpu_sp_adder against a real-arithmetic reference model.
module tb_fpu_sp_adder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] e_res;
  logic        e_val, e_ovf, e_unf;

  fpu_sp_adder_if bus ();

  fpu_sp_adder #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Value of a binary32 pattern with denormals flushed to zero.
  function automatic real fp_val(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    m = m * (2.0 ** e);
    return x[31] ? -m : m;
  endfunction

  // Round a nonzero real to binary32 (RNE, FTZ): returns {overflow, underflow, bits}.
  function automatic logic [33:0] round_real(input real v);
    logic [63:0] d;
    logic [52:0] m53;
    logic        up;
    logic [24:0] m;
    int          e;
    d   = $realtobits(v);
    m53 = {1'b1, d[51:0]};
    up  = m53[28] & ((|m53[27:0]) | m53[29]);
    m   = {1'b0, m53[52:29]} + 25'(up);
    e   = int'(d[62:52]) - 1023 + 127;
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, d[63], 31'd0};
    return {2'b00, d[63], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] to_fp(input real v);
    logic [33:0] r;
    r = round_real(v);
    return r[31:0];
  endfunction

  // Reference sum: {overflow, underflow, result}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic xn, yn, xi, yi;
    real  vx, vy, s;
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    if (xn || yn) return {2'b00, 32'h7FC0_0000};
    if (xi && yi) return (x[31] != y[31]) ? {2'b00, 32'h7FC0_0000} : {2'b00, x};
    if (xi) return {2'b00, x};
    if (yi) return {2'b00, y};
    vx = fp_val(x);
    vy = fp_val(y);
    s  = vx + vy;
    if (s == 0.0) return (vx == 0.0 && vy == 0.0) ? {2'b00, x[31] & y[31], 31'd0} : 34'd0;
    return round_real(s);
  endfunction

  // One clock: drive on the falling edge, update the expected register, compare after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic chk_want, input logic [31:0] want, input string tag);
    logic [33:0] m;
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = ia;
    bus.b        = ib;
    @(posedge clk);
    #1;
    if (r) begin
      e_res = 32'd0; e_val = 1'b0; e_ovf = 1'b0; e_unf = 1'b0;
    end else begin
      e_val = v;
      if (v) begin
        m     = model(ia, ib);
        e_ovf = m[33];
        e_unf = m[32];
        e_res = m[31:0];
      end
    end
    checks++;
    assert (bus.result === e_res) else begin
      errors++;
      $error("FAIL %s result got %h want %h (a=%h b=%h)", tag, bus.result, e_res, ia, ib);
    end
    checks++;
    assert (bus.out_valid === e_val) else begin
      errors++;
      $error("FAIL %s out_valid got %b want %b", tag, bus.out_valid, e_val);
    end
    checks++;
    assert (bus.overflow === e_ovf) else begin
      errors++;
      $error("FAIL %s overflow got %b want %b", tag, bus.overflow, e_ovf);
    end
    checks++;
    assert (bus.underflow === e_unf) else begin
      errors++;
      $error("FAIL %s underflow got %b want %b", tag, bus.underflow, e_unf);
    end
    if (chk_want) begin
      checks++;
      assert (bus.result === want) else begin
        errors++;
        $error("FAIL %s literal got %h want %h", tag, bus.result, want);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0]  eb;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;

    cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0000, "reset");
    cycle(1'b0, 1'b1, 32'h4086_6666, 32'h404C_CCCD, 1'b0, 32'd0, "add_4p2_3p2");
    cycle(1'b0, 1'b1, 32'h40CC_CCCD, 32'hBF00_0000, 1'b1, 32'h40BC_CCCD, "6p4_m0p5");
    cycle(1'b0, 1'b1, to_fp(124054.43), to_fp(-9213743.1), 1'b0, 32'd0, "gap_sub");
    cycle(1'b0, 1'b1, to_fp(121.3232), to_fp(-123.1231), 1'b0, 32'd0, "near_cancel");
    cycle(1'b0, 1'b1, 32'h3F80_0000, 32'hBF80_0000, 1'b1, 32'h0000_0000, "cancel");
    cycle(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, "neg0_neg0");
    cycle(1'b0, 1'b1, 32'h0000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, "pos0_neg0");
    cycle(1'b0, 1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'h7F80_0000, "ovf_pos");
    cycle(1'b0, 1'b1, 32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b1, 32'hFF80_0000, "ovf_neg");
    cycle(1'b0, 1'b1, 32'h0080_0001, 32'h8080_0000, 1'b1, 32'h0000_0000, "underflow");
    cycle(1'b0, 1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, "denorm_ftz");
    cycle(1'b0, 1'b1, 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7FC0_0000, "inf_minf");
    cycle(1'b0, 1'b1, 32'h7FC0_0001, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, "nan_in");
    cycle(1'b0, 1'b1, 32'hFF80_0000, 32'h40A0_0000, 1'b1, 32'hFF80_0000, "minf_fin");
    cycle(1'b0, 1'b1, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7F80_0000, "inf_inf");
    cycle(1'b0, 1'b1, 32'hC123_4567, 32'h0000_0000, 1'b1, 32'hC123_4567, "x_plus_0");
    cycle(1'b0, 1'b0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'd0, "hold");
    cycle(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, "rst_with_valid");

    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, $urandom, $urandom, 1'b0, 32'd0, "back_to_back");
    end

    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) begin
        eb = ra[30:23] - 8'($urandom_range(0, 3));
        rb = {rb[31], eb, rb[22:0]};
      end
      cycle(1'b0, ($urandom_range(0, 7) != 0), ra, rb, 1'b0, 32'd0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
